pma_region_table: RTL and testbench



---
 rtl/pma_pkg.sv | 27 ++
 rtl/pma_match.sv | 39 +++
 rtl/pma_region_table.sv | 215 +++++++++++++++++++++
 tb/tb_pma_region_table.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// Shared types and constants for the runtime-programmable PMA region table.
package pma_pkg;

    localparam int unsigned MissCntWidth = 16;
    localparam int unsigned MaxAddrWidth = 64;

    typedef struct packed {
        logic lock;
        logic nonidem;
        logic exec;
        logic cached;
    } pma_attr_t;

    typedef enum logic [1:0] {
        BASE    = 2'd0,
        LENGTH  = 2'd1,
        ATTR    = 2'd2,
        MISSCNT = 2'd3
    } pma_field_e;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] length;
        pma_attr_t               attr;
    } pma_region_t;

endpackage

// File: rtl/pma_match.sv
// Combinational region matcher for one address: base <= addr < base+length,
// with the lowest matching index winning. Index is 0 on a miss.
module pma_match
    import pma_pkg::*;
#(
    parameter int unsigned NrRegions = 8,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = 3
) (
    input  logic [AddrWidth-1:0]                addr,
    input  logic [NrRegions-1:0][AddrWidth-1:0] base,
    input  logic [NrRegions-1:0][AddrWidth-1:0] length,
    output logic                                hit,
    output logic [IdxW-1:0]                     idx
);

    logic [NrRegions-1:0] match;

    // The end address is formed one bit wider so a region reaching 2^AddrWidth never wraps.
    always_comb begin
        for (int i = 0; i < NrRegions; i++) begin
            match[i] = (length[i] != '0)
                && ({1'b0, addr} >= {1'b0, base[i]})
                && ({1'b0, addr} < ({1'b0, base[i]} + {1'b0, length[i]}));
        end
    end

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NrRegions - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table with a register config port and registered lookups.
// Optional build macro PMA_LOCK_EN: store and enforce a sticky per-region lock bit.
module pma_region_table
    import pma_pkg::*;
#(
    parameter int unsigned NrRegions     = 8,
    parameter int unsigned NrLookupPorts = 2,
    parameter int unsigned AddrWidth     = 64,
    parameter logic [NrRegions*AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRegions*AddrWidth-1:0] RstLength = '0,
    parameter logic [NrRegions*4-1:0]         RstAttr   = '0,
    localparam int unsigned IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              cfg_req_i,
    input  logic                              cfg_we_i,
    input  logic [IdxW-1:0]                   cfg_idx_i,
    input  logic [1:0]                        cfg_field_i,
    input  logic [AddrWidth-1:0]              cfg_wdata_i,
    output logic                              cfg_rvalid_o,
    output logic [AddrWidth-1:0]              cfg_rdata_o,
    output logic                              cfg_err_o,
    input  logic [NrLookupPorts-1:0]          lk_valid_i,
    input  logic [NrLookupPorts*AddrWidth-1:0] lk_addr_i,
    output logic [NrLookupPorts-1:0]          lk_valid_o,
    output logic [NrLookupPorts-1:0]          lk_hit_o,
    output logic [NrLookupPorts*IdxW-1:0]     lk_idx_o,
    output logic [NrLookupPorts-1:0]          lk_cached_o,
    output logic [NrLookupPorts-1:0]          lk_exec_o,
    output logic [NrLookupPorts-1:0]          lk_nonidem_o
);

    logic [NrRegions-1:0][AddrWidth-1:0] base_q;
    logic [NrRegions-1:0][AddrWidth-1:0] length_q;
    logic [NrRegions-1:0]                cached_q;
    logic [NrRegions-1:0]                exec_q;
    logic [NrRegions-1:0]                nonidem_q;
`ifdef PMA_LOCK_EN
    logic [NrRegions-1:0]                lock_q;
`endif

    logic [NrLookupPorts-1:0][MissCntWidth-1:0] miss_q;

    pma_field_e              field;
    pma_attr_t               wattr;
    logic                    port_ok;
    logic                    locked;
    logic                    wr_table;
    logic                    clr_miss;
    logic [AddrWidth-1:0]    rdata_d;
    logic                    err_d;

    assign field    = pma_field_e'(cfg_field_i);
    assign wattr    = pma_attr_t'(cfg_wdata_i[3:0]);
    assign port_ok  = 32'(cfg_idx_i) < NrLookupPorts;
    assign wr_table = cfg_req_i && cfg_we_i && (field != MISSCNT) && !locked;
    assign clr_miss = cfg_req_i && cfg_we_i && (field == MISSCNT) && port_ok;

    always_comb begin
        locked = 1'b0;
`ifdef PMA_LOCK_EN
        for (int i = 0; i < NrRegions; i++) begin
            if (32'(cfg_idx_i) == i) locked = lock_q[i];
        end
`endif
    end

    // Config response is formed from the current table, so a read right after a write sees it.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (field == MISSCNT) begin
            if (!port_ok) begin
                err_d = 1'b1;
            end else if (!cfg_we_i) begin
                for (int p = 0; p < NrLookupPorts; p++) begin
                    if (32'(cfg_idx_i) == p) rdata_d[MissCntWidth-1:0] = miss_q[p];
                end
            end
        end else if (cfg_we_i) begin
            err_d = locked;
        end else begin
            for (int i = 0; i < NrRegions; i++) begin
                if (32'(cfg_idx_i) == i) begin
                    case (field)
                        BASE:    rdata_d = base_q[i];
                        LENGTH:  rdata_d = length_q[i];
                        default: begin
`ifdef PMA_LOCK_EN
                            rdata_d[3] = lock_q[i];
`endif
                            rdata_d[2:0] = {nonidem_q[i], exec_q[i], cached_q[i]};
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i && err_d;
            cfg_rdata_o  <= cfg_req_i ? rdata_d : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q   <= RstBase;
            length_q <= RstLength;
            for (int i = 0; i < NrRegions; i++) begin
                cached_q[i]  <= RstAttr[4*i];
                exec_q[i]    <= RstAttr[4*i+1];
                nonidem_q[i] <= RstAttr[4*i+2];
`ifdef PMA_LOCK_EN
                lock_q[i]    <= RstAttr[4*i+3];
`endif
            end
        end else if (wr_table) begin
            for (int i = 0; i < NrRegions; i++) begin
                if (32'(cfg_idx_i) == i) begin
                    case (field)
                        BASE:   base_q[i]   <= cfg_wdata_i;
                        LENGTH: length_q[i] <= cfg_wdata_i;
                        ATTR: begin
                            cached_q[i]  <= wattr.cached;
                            exec_q[i]    <= wattr.exec;
                            nonidem_q[i] <= wattr.nonidem;
`ifdef PMA_LOCK_EN
                            lock_q[i]    <= wattr.lock;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [NrLookupPorts-1:0]           hit_c;
    logic [NrLookupPorts-1:0][IdxW-1:0] idx_c;
    logic [NrLookupPorts-1:0]           sel_cached;
    logic [NrLookupPorts-1:0]           sel_exec;
    logic [NrLookupPorts-1:0]           sel_nonidem;

    for (genvar p = 0; p < NrLookupPorts; p++) begin : g_port
        pma_match #(
            .NrRegions (NrRegions),
            .AddrWidth (AddrWidth),
            .IdxW      (IdxW)
        ) u_match (
            .addr   (lk_addr_i[p*AddrWidth +: AddrWidth]),
            .base   (base_q),
            .length (length_q),
            .hit    (hit_c[p]),
            .idx    (idx_c[p])
        );
    end

    // A miss falls back to uncached, non-executable, non-idempotent.
    always_comb begin
        sel_cached  = '0;
        sel_exec    = '0;
        sel_nonidem = '1;
        for (int p = 0; p < NrLookupPorts; p++) begin
            for (int i = 0; i < NrRegions; i++) begin
                if (hit_c[p] && idx_c[p] == IdxW'(i)) begin
                    sel_cached[p]  = cached_q[i];
                    sel_exec[p]    = exec_q[i];
                    sel_nonidem[p] = nonidem_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_valid_o   <= '0;
            lk_hit_o     <= '0;
            lk_idx_o     <= '0;
            lk_cached_o  <= '0;
            lk_exec_o    <= '0;
            lk_nonidem_o <= '0;
        end else begin
            lk_valid_o   <= lk_valid_i;
            lk_hit_o     <= lk_valid_i & hit_c;
            lk_idx_o     <= idx_c;
            lk_cached_o  <= sel_cached;
            lk_exec_o    <= sel_exec;
            lk_nonidem_o <= sel_nonidem;
        end
    end

    // A clear from the config port overrides a miss increment in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_q <= '0;
        end else begin
            for (int p = 0; p < NrLookupPorts; p++) begin
                if (clr_miss && 32'(cfg_idx_i) == p) begin
                    miss_q[p] <= '0;
                end else if (lk_valid_i[p] && !hit_c[p] && miss_q[p] != '1) begin
                    miss_q[p] <= miss_q[p] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pma_region_table.sv
// Randomized and directed bench for pma_region_table against a behavioural table model.
module tb_pma_region_table;
    import pma_pkg::*;

    localparam int NR = 8;
    localparam int NP = 2;
    localparam int AW = 64;
    localparam logic [NR*AW-1:0] RST_BASE   = 512'h8000_0000;
    localparam logic [NR*AW-1:0] RST_LENGTH = 512'h4000_0000;
    localparam logic [NR*4-1:0]  RST_ATTR   = 32'h3;
`ifdef PMA_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_req, cfg_we;
    logic [2:0]    cfg_idx;
    logic [1:0]    cfg_field;
    logic [63:0]   cfg_wdata;
    logic          cfg_rvalid, cfg_err;
    logic [63:0]   cfg_rdata;
    logic [1:0]    lk_valid_in;
    logic [127:0]  lk_addr;
    logic [1:0]    lk_valid_out, lk_hit, lk_cached, lk_exec, lk_nonidem;
    logic [5:0]    lk_idx;

    int n_tests = 0;
    int n_fail  = 0;

    pma_region_t m_reg [NR];
    int unsigned m_miss [NP];

    always #5 clk = ~clk;

    pma_region_table #(
        .NrRegions     (NR),
        .NrLookupPorts (NP),
        .AddrWidth     (AW),
        .RstBase       (RST_BASE),
        .RstLength     (RST_LENGTH),
        .RstAttr       (RST_ATTR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_req_i    (cfg_req),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_field_i  (cfg_field),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rvalid_o (cfg_rvalid),
        .cfg_rdata_o  (cfg_rdata),
        .cfg_err_o    (cfg_err),
        .lk_valid_i   (lk_valid_in),
        .lk_addr_i    (lk_addr),
        .lk_valid_o   (lk_valid_out),
        .lk_hit_o     (lk_hit),
        .lk_idx_o     (lk_idx),
        .lk_cached_o  (lk_cached),
        .lk_exec_o    (lk_exec),
        .lk_nonidem_o (lk_nonidem)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        logic [NR*AW-1:0] rb;
        logic [NR*AW-1:0] rl;
        logic [NR*4-1:0]  ra;
        rb = RST_BASE;
        rl = RST_LENGTH;
        ra = RST_ATTR;
        for (int i = 0; i < NR; i++) begin
            m_reg[i].base   = rb[i*AW +: AW];
            m_reg[i].length = rl[i*AW +: AW];
            m_reg[i].attr   = pma_attr_t'(ra[i*4 +: 4]);
            if (!LockEn) m_reg[i].attr.lock = 1'b0;
        end
        for (int p = 0; p < NP; p++) m_miss[p] = 0;
    endtask

    // Lowest-index enabled region containing the address, or the safe I/O default.
    task automatic model_lookup(input logic [63:0] a, output logic hit, output logic [2:0] idx,
                                output logic [2:0] att);
        hit = 1'b0;
        idx = 3'd0;
        att = 3'b100;
        for (int i = 0; i < NR; i++) begin
            if (!hit && m_reg[i].length != 0 && a >= m_reg[i].base
                && (a - m_reg[i].base) < m_reg[i].length) begin
                hit = 1'b1;
                idx = 3'(i);
                att = {m_reg[i].attr.nonidem, m_reg[i].attr.exec, m_reg[i].attr.cached};
            end
        end
    endtask

    task automatic idle();
        cfg_req     = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_field   = '0;
        cfg_wdata   = '0;
        lk_valid_in = '0;
        lk_addr     = '0;
    endtask

    task automatic cfg(input bit we, input int idx, input int field, input logic [63:0] d);
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_idx   = 3'(idx);
        cfg_field = 2'(field);
        cfg_wdata = d;
    endtask

    task automatic lk(input int p, input logic [63:0] a);
        lk_valid_in[p]     = 1'b1;
        lk_addr[p*64 +: 64] = a;
    endtask

    // One clock: predict from pre-edge model state, update the model, then compare.
    task automatic cycle();
        logic        e_rv, e_err;
        logic [63:0] e_rd;
        logic        e_hit [NP];
        logic [2:0]  e_idx [NP];
        logic [2:0]  e_att [NP];
        logic [1:0]  e_v;
        e_v = lk_valid_in;
        for (int p = 0; p < NP; p++) model_lookup(lk_addr[p*64 +: 64], e_hit[p], e_idx[p], e_att[p]);
        e_rv = cfg_req; e_err = 1'b0; e_rd = '0;
        if (cfg_req) begin
            if (cfg_field == 2'd3) begin
                if (cfg_idx >= NP) e_err = 1'b1;
                else if (!cfg_we) e_rd = 64'(m_miss[cfg_idx]);
            end else if (cfg_we) begin
                e_err = m_reg[cfg_idx].attr.lock;
            end else begin
                case (cfg_field)
                    2'd0:    e_rd = m_reg[cfg_idx].base;
                    2'd1:    e_rd = m_reg[cfg_idx].length;
                    default: e_rd = {60'd0, m_reg[cfg_idx].attr};
                endcase
            end
        end
        for (int p = 0; p < NP; p++)
            if (e_v[p] && !e_hit[p] && m_miss[p] < 65535) m_miss[p]++;
        if (cfg_req && cfg_we) begin
            if (cfg_field == 2'd3) begin
                if (cfg_idx < NP) m_miss[cfg_idx] = 0;
            end else if (!m_reg[cfg_idx].attr.lock) begin
                case (cfg_field)
                    2'd0:    m_reg[cfg_idx].base   = cfg_wdata;
                    2'd1:    m_reg[cfg_idx].length = cfg_wdata;
                    default: begin
                        m_reg[cfg_idx].attr = pma_attr_t'(cfg_wdata[3:0]);
                        if (!LockEn) m_reg[cfg_idx].attr.lock = 1'b0;
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        check("cfg_rvalid", cfg_rvalid, e_rv);
        if (e_rv) begin
            check("cfg_rdata", cfg_rdata, e_rd);
            check("cfg_err", cfg_err, e_err);
        end
        for (int p = 0; p < NP; p++) begin
            check($sformatf("lk_valid%0d", p), lk_valid_out[p], e_v[p]);
            if (e_v[p]) begin
                check($sformatf("lk_hit%0d", p), lk_hit[p], e_hit[p]);
                check($sformatf("lk_idx%0d", p), lk_idx[p*3 +: 3], e_idx[p]);
                check($sformatf("lk_attr%0d", p), {lk_nonidem[p], lk_exec[p], lk_cached[p]}, e_att[p]);
            end
        end
    endtask

    task automatic step();
        cycle();
        idle();
    endtask

    task automatic pick_addr(output logic [63:0] a);
        int r;
        r = $urandom_range(0, NR - 1);
        case ($urandom_range(0, 4))
            0:       a = m_reg[r].base;
            1:       a = m_reg[r].base + m_reg[r].length - 1;
            2:       a = m_reg[r].base + m_reg[r].length;
            3:       a = m_reg[r].base - 1;
            default: a = 64'($urandom_range(0, 32'h2_0000));
        endcase
    endtask

    initial begin
        logic [63:0] a;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", cfg_rvalid, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_rdata", cfg_rdata, 64'd0);
        check("rst_lk_valid", lk_valid_out, 2'b00);
        check("rst_lk_hit", lk_hit, 2'b00);
        rst = 1'b0;

        lk(0, 64'h8000_1000); lk(1, 64'hC000_0000); step();
        check("reset_region_hit", lk_hit[0], 1'b1);
        check("exact_end_miss", lk_hit[1], 1'b0);
        check("exact_end_nonidem", lk_nonidem[1], 1'b1);

        cfg(1, 5, 0, 64'hFFFF_FFFF_FFFF_F000); step();
        cfg(1, 5, 1, 64'h1000); step();
        lk(0, 64'hFFFF_FFFF_FFFF_FFFF); step();
        check("top_of_space_hit", lk_hit[0], 1'b1);

        cfg(1, 1, 0, 64'h1_0000); step();
        cfg(1, 1, 1, 64'h1000); step();
        cfg(1, 3, 1, 64'h2_0000); step();
        lk(0, 64'h1_0000); step();
        check("overlap_idx1", lk_idx[2:0], 3'd1);
        cfg(1, 1, 1, 64'h0); step();
        lk(0, 64'h1_0000); step();
        check("overlap_idx3", lk_idx[2:0], 3'd3);

        cfg(1, 2, 1, 64'h100); step();
        cfg(1, 2, 0, 64'h5000_0000); lk(1, 64'h5000_0000); step();
        check("race_pre_write_miss", lk_hit[1], 1'b0);
        cfg(0, 2, 0, 64'h0); lk(1, 64'h5000_0000); step();
        check("race_next_hit", lk_hit[1], 1'b1);
        check("read_after_write", cfg_rdata, 64'h5000_0000);

        cfg(1, 4, 2, 64'h9); step();
        cfg(1, 4, 0, 64'h1234_0000); step();
        check("locked_write_err", cfg_err, LockEn);
        cfg(0, 4, 0, 64'h0); step();
        check("locked_base_read", cfg_rdata, LockEn ? 64'h0 : 64'h1234_0000);
        cfg(1, 4, 2, 64'h1); step();
        check("lock_sticky_err", cfg_err, LockEn);

        cfg(0, 2, 3, 64'h0); step();
        check("miss_idx_range_err", cfg_err, 1'b1);

        repeat (70000) begin
            lk(1, 64'h0300_0000); step();
        end
        cfg(0, 1, 3, 64'h0); step();
        check("miss_saturated", cfg_rdata, 64'hFFFF);
        cfg(1, 1, 3, 64'h0); lk(1, 64'h0300_0000); step();
        cfg(0, 1, 3, 64'h0); step();
        check("miss_clear_wins", cfg_rdata, 64'h0);

        repeat (1500) begin
            if ($urandom_range(0, 1) == 1) begin
                int f;
                logic [63:0] d;
                f = $urandom_range(0, 3);
                case (f)
                    0:       d = 64'($urandom_range(0, 15)) << 12;
                    1:       d = 64'($urandom_range(0, 8)) << 12;
                    default: d = 64'($urandom_range(0, 15));
                endcase
                cfg($urandom_range(0, 1) == 1, $urandom_range(0, NR - 1), f, d);
            end
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    pick_addr(a);
                    lk(p, a);
                end
            end
            step();
        end

        cfg(0, 0, 0, 64'h0); lk(0, 64'h8000_0000); lk(1, 64'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_lk_valid", lk_valid_out, 2'b00);
        check("midrst_rvalid", cfg_rvalid, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_lk_valid_edge", lk_valid_out, 2'b00);
        idle();
        rst = 1'b0;
        model_reset();
        step();
        lk(0, 64'h8000_0000); cfg(0, 1, 3, 64'h0); step();
        check("post_rst_region0", lk_hit[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
